// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NCH valid/ready demultiplexer with explicit-select or round-robin routing.
// Optional per-channel and drop statistics counters: define DEMUX_STREAM_STAT_EN.
module demux_stream_1ton #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SELW-1:0]        in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [SELW-1:0]        rr_ptr,
`ifdef DEMUX_STREAM_STAT_EN
  output logic [NCH*16-1:0]      stat_cnt,
  output logic [15:0]            drop_cnt,
`endif
  output logic                   drop_pulse
);

  localparam logic [SELW:0]   NCH_L = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH-1);

  logic [NCH-1:0]       out_valid_q, out_valid_d;
  logic [NCH*WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]      rr_ptr_q,    rr_ptr_d;
  logic                 drop_q,      drop_d;

  logic [SELW-1:0] tgt;
  logic            tgt_ok;
  logic            tgt_free;
  logic            accept;
  logic            wr_en;

  always_comb begin
    tgt      = mode ? rr_ptr_q : in_sel;
    tgt_ok   = ({1'b0, tgt} < NCH_L);
    tgt_free = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (tgt == SELW'(k)) tgt_free = ~out_valid_q[k] | out_ready[k];
    end
    // Out-of-range target only arises from in_sel in mode 0; such words are swallowed.
    in_ready = tgt_ok ? tgt_free : ~mode;
    accept   = in_valid & in_ready;
    wr_en    = accept & tgt_ok;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (wr_en && (tgt == SELW'(k))) begin
        out_valid_d[k]                = 1'b1;
        out_data_d[k*WIDTH +: WIDTH]  = in_data;
      end else if (out_valid_q[k] && out_ready[k]) begin
        out_valid_d[k]                = 1'b0;
        out_data_d[k*WIDTH +: WIDTH]  = '0;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (accept && mode) rr_ptr_d = (rr_ptr_q == LAST) ? '0 : rr_ptr_q + 1'b1;
    drop_d = accept & ~tgt_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign rr_ptr     = rr_ptr_q;
  assign drop_pulse = drop_q;

`ifdef DEMUX_STREAM_STAT_EN
  logic [NCH-1:0][15:0] stat_q;
  logic [15:0]          drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (wr_en && (tgt == SELW'(k)) && (stat_q[k] != '1)) stat_q[k] <= stat_q[k] + 16'd1;
      end
      if (drop_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign stat_cnt = stat_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton (NCH=4, SELW=3 so in_sel 4..7 exercises the drop path).
module tb_demux_stream_1ton;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [SELW-1:0]      in_sel;
  logic [WIDTH-1:0]     in_data;
  logic [NCH-1:0]       out_valid;
  logic [NCH-1:0]       out_ready;
  logic [NCH*WIDTH-1:0] out_data;
  logic [SELW-1:0]      rr_ptr;
  logic                 drop_pulse;
`ifdef DEMUX_STREAM_STAT_EN
  logic [NCH*16-1:0]    stat_cnt;
  logic [15:0]          drop_cnt;
`endif

  demux_stream_1ton #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr),
`ifdef DEMUX_STREAM_STAT_EN
    .stat_cnt(stat_cnt), .drop_cnt(drop_cnt),
`endif
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: channel contents, round-robin position, drop flag, counters.
  logic       m_v[NCH];
  logic [7:0] m_d[NCH];
  int         m_rr;
  logic       m_drop;
  int         m_stat[NCH];
  int         m_dropcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      m_v[k] = 1'b0; m_d[k] = 8'h00; m_stat[k] = 0;
    end
    m_rr = 0; m_drop = 1'b0; m_dropcnt = 0;
  endtask

  task automatic drive(input logic rst_n, input logic md, input logic v,
                       input int sel, input logic [7:0] d, input logic [NCH-1:0] rdy);
    reset_n   = rst_n;
    mode      = md;
    in_valid  = v;
    in_sel    = SELW'(sel);
    in_data   = d;
    out_ready = rdy;
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic cycle();
    int t;
    logic er;
    logic acc;
    logic [NCH-1:0] ev;
    logic [NCH*WIDTH-1:0] ed;
    #1;
    t  = mode ? m_rr : int'(in_sel);
    er = (t >= NCH) ? !mode : (!m_v[t] || out_ready[t]);
    chk("in_ready", {63'd0, in_ready}, {63'd0, er});
    acc = in_valid && er;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (m_v[k] && out_ready[k]) begin m_v[k] = 1'b0; m_d[k] = 8'h00; end
      end
      m_drop = acc && (t >= NCH);
      if (m_drop && m_dropcnt < 65535) m_dropcnt++;
      if (acc && t < NCH) begin
        m_v[t] = 1'b1; m_d[t] = in_data;
        if (m_stat[t] < 65535) m_stat[t]++;
      end
      if (acc && mode) m_rr = (m_rr + 1) % NCH;
    end
    @(negedge clk);
    for (int k = 0; k < NCH; k++) begin
      ev[k] = m_v[k];
      ed[k*WIDTH +: WIDTH] = m_d[k];
    end
    chk("out_valid",  {60'd0, out_valid}, {60'd0, ev});
    chk("out_data",   {32'd0, out_data},  {32'd0, ed});
    chk("rr_ptr",     {61'd0, rr_ptr},    64'(m_rr));
    chk("drop_pulse", {63'd0, drop_pulse}, {63'd0, m_drop});
`ifdef DEMUX_STREAM_STAT_EN
    for (int k = 0; k < NCH; k++) chk("stat_cnt", {48'd0, stat_cnt[k*16 +: 16]}, 64'(m_stat[k]));
    chk("drop_cnt", {48'd0, drop_cnt}, 64'(m_dropcnt));
`endif
  endtask

  initial begin
    model_clear();
    drive(1'b0, 1'b0, 1'b0, 0, 8'h00, '1);
    @(negedge clk);
    cycle(); cycle();
    chk("reset_valid", {60'd0, out_valid}, 64'd0);
    chk("reset_rr",    {61'd0, rr_ptr},    64'd0);

    // Single explicit-select word, then drain
    drive(1'b1, 1'b0, 1'b1, 2, 8'hA5, 4'b1111); cycle();
    chk("sel2_valid", {60'd0, out_valid}, 64'b0100);
    chk("sel2_data",  {56'd0, out_data[23:16]}, 64'hA5);
    drive(1'b1, 1'b0, 1'b0, 2, 8'h00, 4'b1111); cycle();
    chk("drain_valid", {60'd0, out_valid}, 64'd0);
    chk("drain_data",  {32'd0, out_data},  64'd0);

    // Backpressure on channel 1, then coincident drain+refill
    drive(1'b1, 1'b0, 1'b1, 1, 8'h11, 4'b1101); cycle();
    drive(1'b1, 1'b0, 1'b1, 1, 8'h22, 4'b1101); cycle();
    chk("bp_stall", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("bp_hold", {56'd0, out_data[15:8]}, 64'h11);
    drive(1'b1, 1'b0, 1'b1, 1, 8'h22, 4'b1111); cycle();
    chk("bp_refill", {56'd0, out_data[15:8]}, 64'h22);
    drive(1'b1, 1'b0, 1'b0, 0, 8'h00, 4'b1111); cycle();

    // Round-robin 6 words: channels 0,1,2,3,0,1
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, 7, 8'(i), 4'b1111); cycle();
    end
    chk("rr_end", {61'd0, rr_ptr}, 64'd2);
    chk("rr_last_ch1", {56'd0, out_data[15:8]}, 64'h06);

    // Round-robin stall: reach rr=1, fill ch1 in mode 0, stall in mode 1
    drive(1'b1, 1'b1, 1'b1, 0, 8'h30, 4'b1111); cycle();
    drive(1'b1, 1'b1, 1'b1, 0, 8'h31, 4'b1111); cycle();
    drive(1'b1, 1'b1, 1'b1, 0, 8'h32, 4'b1111); cycle();
    drive(1'b1, 1'b0, 1'b1, 1, 8'h41, 4'b1101); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 0, 8'h42, 4'b1101); cycle();
    end
    chk("rrstall_ptr", {61'd0, rr_ptr}, 64'd1);
    chk("rrstall_ch2", {63'd0, out_valid[2]}, 64'd0);
    drive(1'b1, 1'b1, 1'b1, 0, 8'h42, 4'b1111); cycle();
    chk("rrresume_ptr", {61'd0, rr_ptr}, 64'd2);

    // Invalid select: accepted and dropped, channels untouched
    drive(1'b1, 1'b0, 1'b1, 5, 8'hFF, 4'b0000); cycle();
    chk("drop_pulse_hi", {63'd0, drop_pulse}, 64'd1);
    chk("drop_ch_keep", {60'd0, out_valid}, 64'b0010);
    drive(1'b1, 1'b0, 1'b0, 0, 8'h00, 4'b1111); cycle();

    // Reset mid-operation with ch0/ch2 full and rr=3
    drive(1'b1, 1'b1, 1'b1, 0, 8'h50, 4'b1111); cycle();
    drive(1'b1, 1'b0, 1'b0, 0, 8'h00, 4'b1111); cycle();
    drive(1'b1, 1'b0, 1'b1, 0, 8'h60, 4'b0000); cycle();
    drive(1'b1, 1'b0, 1'b1, 2, 8'h62, 4'b0000); cycle();
    chk("pre_rst_rr", {61'd0, rr_ptr}, 64'd3);
    drive(1'b0, 1'b1, 1'b1, 0, 8'h77, 4'b0000); cycle();
    chk("rst_valid", {60'd0, out_valid}, 64'd0);
    chk("rst_data",  {32'd0, out_data},  64'd0);
    chk("rst_rr",    {61'd0, rr_ptr},    64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), 8'($urandom), NCH'($urandom));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_stream_1ton.md
Name: demux_stream_1ton

Overview:
Registered, parametrised 1-to-NCH demultiplexer for valid/ready streams, generalising the team's 1-to-2 combinational demux.
- Each output channel owns a one-entry output register; backpressure is applied per channel.
- Two routing modes: explicit select, or round-robin distribution (e.g. odd/even split when NCH=2).
- Sits between a single producer and NCH downstream consumers in the datapath.

Parameters:
WIDTH, 8, data width in bits
NCH, 4, number of output channels (2..16)
SELW, 2, select/pointer width; must satisfy NCH <= 2**SELW

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
mode  input  1  0 = explicit select routing, 1 = round-robin routing
in_valid  input  1  input word valid
in_ready  output  1  input may be accepted this cycle
in_sel  input  SELW  target channel in mode 0; ignored in mode 1
in_data  input  WIDTH  input word
out_valid  output  NCH  bit k: channel k register holds a word
out_ready  input  NCH  bit k: consumer k accepts this cycle
out_data  output  NCH*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
rr_ptr  output  SELW  current round-robin target channel
drop_pulse  output  1  one-cycle pulse: word accepted and discarded

Behaviour:
- Reset (reset_n=0 at a clock edge): out_valid=0, out_data=0, rr_ptr=0, drop_pulse=0. All in-flight words are discarded. Reset overrides any handshake in the same cycle.
- Target channel t = in_sel when mode=0, t = rr_ptr when mode=1.
- Channel k is free when out_valid[k]=0 or out_ready[k]=1. A drain and a refill in the same cycle are allowed, giving full throughput.
- in_ready is combinational:
  - 1 if t is free;
  - 1 if mode=0 and in_sel >= NCH (drop case);
  - 0 otherwise.
- Accept means in_valid and in_ready are both 1. On accept to a valid t, on the next edge out_data[t] <= in_data and out_valid[t] <= 1. Latency is 1 cycle from accept to out_valid.
- Drain: out_valid[k] and out_ready[k] both 1, with no refill of k, gives out_valid[k] <= 0 and out_data[k] <= 0. Data is zero whenever the channel is empty.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] must not change.
- Invalid select (mode=0, in_sel >= NCH): the word is accepted and discarded, drop_pulse=1 on the next cycle, and no channel changes.
- Round-robin:
  - rr_ptr advances by 1 on each accept in mode 1, wrapping NCH-1 -> 0.
  - If the target is not free, input stalls; full channels are never skipped (strict order).
  - In mode 0, rr_ptr holds its value.
  - On a mode 0 -> 1 change, round-robin resumes from the held rr_ptr.
- Mode or in_sel changes while in_valid=1 and in_ready=0 are legal. Routing uses values sampled in the accept cycle only.
- Only one channel can be written per cycle. Any number of channels may drain in the same cycle.
- No combinational path from in_* to out_valid or out_data. The only combinational paths are in_ready from mode, in_sel, rr_ptr and out_ready.

Optional Feature:
Macro DEMUX_STREAM_STAT_EN.
- Defined: adds output port stat_cnt (NCH*16 bits; channel k at [k*16 +: 16]).
  - Each field is a 16-bit saturating count of words accepted into channel k.
  - Holds at 16'hFFFF once saturated; reset to 0 by reset_n.
  - Adds output drop_cnt (16 bits, saturating), counting drop_pulse events.
- Undefined: neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then mode=0, NCH=4, in_sel=2, in_data=8'hA5, in_valid=1 one cycle, all out_ready=1 -> next cycle out_valid=4'b0100 and out_data[23:16]=8'hA5; the cycle after, out_valid=0 and out_data=0.
- Backpressure: out_ready[1]=0, two words 8'h11 then 8'h22 to in_sel=1 -> first accepted; in_ready=0 for the second until out_ready[1]=1; out_data[1] holds 8'h11 stable; 8'h22 appears the cycle after the drain, with no bubble if the drain and refill coincide.
- Round-robin: mode=1, 6 words 8'h01..8'h06, all ready -> channels 0,1,2,3,0,1 receive them in order; rr_ptr ends at 2; wrap 3->0 verified.
- Round-robin stall: mode=1, rr_ptr=1, out_ready[1]=0 with channel 1 full -> in_ready=0, no word to channel 2, rr_ptr stays 1 until channel 1 drains.
- Invalid select with NCH=3: mode=0, in_sel=3, in_data=8'hFF -> in_ready=1, drop_pulse=1 next cycle, out_valid unchanged. With DEMUX_STREAM_STAT_EN, drop_cnt=1.
- Reset mid-operation: channels 0 and 2 full, rr_ptr=3, reset_n=0 with in_valid=1 at the same edge -> next cycle all outputs zero and rr_ptr=0; the input word is not captured. With the macro, stat_cnt=0.
